// File: rtl/alu_pkg.sv
// Shared encodings for the ALU shift datapath: shift ops, direction and sequencer states.
package alu_pkg;

    typedef enum logic [1:0] {
        SH_LOG = 2'b00,
        SH_ARI = 2'b01,
        SH_ROT = 2'b10,
        SH_RTC = 2'b11
    } shift_op_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } seq_state_e;

endpackage

// File: rtl/shift_step.sv
// One single-bit shift/rotate step: (work, carry, dir, op) -> (next work, next carry).
module shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] w_i,
    input  logic             c_i,
    input  logic             dir_i,
    input  shift_op_e        op_i,
    output logic [WIDTH-1:0] w_next_o,
    output logic             c_next_o
);

    // Every op shifts out the same end bit; only the bit shifted in differs.
    assign c_next_o = (dir_i == DIR_LEFT) ? w_i[WIDTH-1] : w_i[0];

    // NOTE: default assigned first so no path through the case can infer a latch.
    always_comb begin
        w_next_o = w_i;
        case (op_i)
            SH_LOG, SH_ARI: begin
                if (dir_i == DIR_LEFT) begin
                    w_next_o = {w_i[WIDTH-2:0], 1'b0};
                end else begin
                    w_next_o = {(op_i == SH_ARI) ? w_i[WIDTH-1] : 1'b0, w_i[WIDTH-1:1]};
                end
            end
            SH_ROT: begin
                if (dir_i == DIR_LEFT) begin
                    w_next_o = {w_i[WIDTH-2:0], w_i[WIDTH-1]};
                end else begin
                    w_next_o = {w_i[0], w_i[WIDTH-1:1]};
                end
            end
            SH_RTC: begin
                if (dir_i == DIR_LEFT) begin
                    w_next_o = {w_i[WIDTH-2:0], c_i};
                end else begin
                    w_next_o = {c_i, w_i[WIDTH-1:1]};
                end
            end
            default: w_next_o = w_i;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate engine: captures an operand, applies one step per clock,
// and reports the result with carry and zero flags through a start/busy/done handshake.
module shift_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             carry,
    output logic             zero
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    shift_op_e        op_q, op_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] step_w;
    logic             step_c;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .w_i      (work_q),
        .c_i      (carry_q),
        .dir_i    (dir_q),
        .op_i     (op_q),
        .w_next_o (step_w),
        .c_next_o (step_c)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        op_d    = op_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE, DONE: begin
                // A start in the DONE cycle is accepted directly, giving back-to-back ops.
                if (start) begin
                    work_d  = data_in;
                    dir_d   = dir;
                    op_d    = shift_op_e'(op);
                    carry_d = (shift_op_e'(op) == SH_RTC) ? carry_in : 1'b0;
                    cnt_d   = amount;
                    state_d = (amount == '0) ? DONE : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d  = step_w;
                carry_d = step_c;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Zero flag tracks the final work value on every entry to DONE, then holds.
        if (state_d == DONE) begin
            zero_d = (work_d == '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments; every register, control
    // included, is reset so an aborted operation leaves no stale state behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            dir_q   <= DIR_LEFT;
            op_q    <= SH_LOG;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            op_q    <= op_d;
            zero_q  <= zero_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign data_out = work_q;
    assign carry    = carry_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus randomized ops vs. a behavioural model.
module tb_shift_sequencer;

    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          dir;
    logic [1:0]    op;
    logic [CW-1:0] amount;
    logic [W-1:0]  data_in;
    logic          carry_in;
    logic          busy;
    logic          done;
    logic [W-1:0]  data_out;
    logic          carry;
    logic          zero;

    int n_checks = 0;
    int n_fail   = 0;

    shift_sequencer #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dir      (dir),
        .op       (op),
        .amount   (amount),
        .data_in  (data_in),
        .carry_in (carry_in),
        .busy     (busy),
        .done     (done),
        .data_out (data_out),
        .carry    (carry),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Whole-operation reference: returns {carry, result} computed directly from the distance.
    function automatic logic [8:0] model(input logic d, input logic [1:0] o, input int amt,
                                         input logic [7:0] x, input logic cin);
        logic [7:0] r;
        logic       c;
        logic [8:0] v;
        if (amt == 0) return {(o == 2'b11) ? cin : 1'b0, x};
        r = x;
        c = 1'b0;
        case (o)
            2'b00, 2'b01: begin
                if (d == 1'b0) begin
                    r = x << amt;
                    c = x[8 - amt];
                end else begin
                    if (o == 2'b01) r = $signed(x) >>> amt;
                    else            r = x >> amt;
                    c = x[amt - 1];
                end
            end
            2'b10: begin
                if (d == 1'b0) begin
                    r = (x << amt) | (x >> (8 - amt));
                    c = r[0];
                end else begin
                    r = (x >> amt) | (x << (8 - amt));
                    c = r[7];
                end
            end
            default: begin
                v = {cin, x};
                if (d == 1'b0) v = (v << amt) | (v >> (9 - amt));
                else           v = (v >> amt) | (v << (9 - amt));
                c = v[8];
                r = v[7:0];
            end
        endcase
        return {c, r};
    endfunction

    // Called #1 after a rising edge; start is sampled at the following edge.
    task automatic issue(input logic d, input logic [1:0] o, input int amt,
                         input logic [7:0] x, input logic cin);
        dir      = d;
        op       = o;
        amount   = amt[CW-1:0];
        data_in  = x;
        carry_in = cin;
        start    = 1'b1;
    endtask

    // Passes the sampling edge, waits for done (bounded) and checks latency and results.
    // With hold set, start stays high and the inputs are scrambled while busy.
    task automatic finish_op(input string tag, input int amt, input logic [8:0] exp, input bit hold);
        int k;
        @(posedge clk); #1;
        if (hold) data_in = ~data_in;
        else      start   = 1'b0;
        check({tag, "/busy_after_start"}, busy, amt != 0);
        k = 0;
        while (!done && k < amt + 4) begin
            @(posedge clk); #1;
            k++;
        end
        if (hold) start = 1'b0;
        check({tag, "/latency"}, k, amt);
        check({tag, "/data_out"}, data_out, exp[7:0]);
        check({tag, "/carry"}, carry, exp[8]);
        check({tag, "/zero"}, zero, exp[7:0] == 8'h00);
        check({tag, "/busy_in_done"}, busy, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic d, input logic [1:0] o, input int amt,
                          input logic [7:0] x, input logic cin, input bit hold);
        issue(d, o, amt, x, cin);
        finish_op(tag, amt, model(d, o, amt, x, cin), hold);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/busy"}, busy, 1'b0);
        check({tag, "/done"}, done, 1'b0);
        check({tag, "/data_out"}, data_out, 8'h00);
        check({tag, "/carry"}, carry, 1'b0);
        check({tag, "/zero"}, zero, 1'b0);
    endtask

    initial begin
        int done_seen;
        logic [8:0] exp1;
        rst_n    = 1'b0;
        start    = 1'b0;
        dir      = 1'b0;
        op       = 2'b00;
        amount   = '0;
        data_in  = '0;
        carry_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("idle_after_reset");

        // Directed cases from the operation examples.
        run_op("lsl_CA_3",  1'b0, 2'b00, 3, 8'hCA, 1'b0, 1'b0);
        run_op("asr_96_2",  1'b1, 2'b01, 2, 8'h96, 1'b0, 1'b0);
        run_op("lsr_96_2",  1'b1, 2'b00, 2, 8'h96, 1'b1, 1'b0);
        run_op("rol_81_1",  1'b0, 2'b10, 1, 8'h81, 1'b0, 1'b0);
        run_op("rcr_01_1",  1'b1, 2'b11, 1, 8'h01, 1'b0, 1'b0);
        run_op("amt0_0F",   1'b0, 2'b11, 0, 8'h0F, 1'b1, 1'b0);
        run_op("rcl_80_7",  1'b0, 2'b11, 7, 8'h80, 1'b1, 1'b0);
        run_op("asr_80_7",  1'b1, 2'b01, 7, 8'h80, 1'b0, 1'b0);

        // Start held high through busy: ignored, then DONE falls back to IDLE.
        run_op("hold", 1'b0, 2'b10, 4, 8'hA5, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("hold/idle_busy", busy, 1'b0);
        check("hold/idle_done", done, 1'b0);

        // Back-to-back: second start issued in the first op's done cycle.
        run_op("b2b_first", 1'b1, 2'b00, 3, 8'hF0, 1'b0, 1'b0);
        run_op("b2b_second", 1'b0, 2'b01, 2, 8'h3C, 1'b0, 1'b0);
        run_op("b2b_third_amt0", 1'b1, 2'b10, 0, 8'h00, 1'b1, 1'b0);

        // Reset in the middle of a SHIFT aborts the operation.
        @(posedge clk); #1;
        issue(1'b0, 2'b00, 5, 8'hFF, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("midrst/busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        check("midrst/no_done_after_release", done_seen, 0);

        // Randomized ops, with random idle gaps (gap 0 is back-to-back).
        for (int i = 0; i < 60; i++) begin
            logic       rd;
            logic [1:0] ro;
            int         ra;
            logic [7:0] rx;
            logic       rc;
            int         gap;
            rd  = 1'($urandom_range(0, 1));
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom_range(0, W - 1);
            rx  = 8'($urandom);
            rc  = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 2);
            exp1 = model(rd, ro, ra, rx, rc);
            issue(rd, ro, ra, rx, rc);
            finish_op($sformatf("rand%0d", i), ra, exp1, 1'b0);
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
